// File: rtl/sram_responder_if.sv
// sram_responder_if -- asynchronous-SRAM style pin bundle seen by the responder.
//
// Signals (all driven by the master, sampled by the responder):
//   SRAM_CE    chip enable, active low
//   SRAM_UB    upper byte [15:8] enable, active low
//   SRAM_LB    lower byte [7:0] enable, active low
//   SRAM_OE    output enable, active low
//   SRAM_WE    write enable, active low
//   SRAM_ADDR  20-bit word address
// The bidirectional data bus SRAM_DQ stays a plain inout on the responder so
// that its tristate driver is resolved on an ordinary net.
interface sram_responder_if;
  logic        SRAM_CE;
  logic        SRAM_UB;
  logic        SRAM_LB;
  logic        SRAM_OE;
  logic        SRAM_WE;
  logic [19:0] SRAM_ADDR;

  modport master (
    output SRAM_CE, SRAM_UB, SRAM_LB, SRAM_OE, SRAM_WE, SRAM_ADDR
  );

  modport slave (
    input SRAM_CE, SRAM_UB, SRAM_LB, SRAM_OE, SRAM_WE, SRAM_ADDR
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder -- behavioural SRAM slave with init sweep, byte lanes,
// configurable read latency and protocol-violation accounting.
//
// Parameters:
//   ADDR_BITS     implemented depth is 2^ADDR_BITS 16-bit words
//   READ_LATENCY  1 or 2 cycles from a sampled read to valid SRAM_DQ data
//   INIT_VALUE    word written everywhere by the post-reset sweep
// Ports:
//   sram_clk   sole clock, rising edge
//   reset      synchronous, active-high
//   bus        SRAM control/address pins (slave modport)
//   SRAM_DQ    bidirectional data, driven only for a valid read result
//   ready      high once the init sweep has completed
//   err_count  saturating protocol-violation counter
//   wr_count   accepted write counter (wraps)
//   rd_count   accepted read counter (wraps)
module sram_responder #(
  parameter int          ADDR_BITS    = 12,
  parameter int          READ_LATENCY = 1,
  parameter logic [15:0] INIT_VALUE   = 16'h0000
) (
  input  logic               sram_clk,
  input  logic               reset,
  sram_responder_if.slave    bus,
  inout  wire  [15:0]        SRAM_DQ,
  output logic               ready,
  output logic [7:0]         err_count,
  output logic [15:0]        wr_count,
  output logic [15:0]        rd_count
);

  localparam int DEPTH = 1 << ADDR_BITS;
  // Any value other than 2 behaves as single-cycle latency.
  localparam int LAT   = (READ_LATENCY == 2) ? 2 : 1;

  // Sweep counter runs one past the last word so the READY transition lands
  // on the cycle after the final word is written.
  localparam logic [ADDR_BITS:0] SWEEP_END  = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] SWEEP_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS:0] SWEEP_ZERO = {(ADDR_BITS + 1){1'b0}};

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e               state_r;
  state_e               state_nxt_s;
  logic [ADDR_BITS:0]   sweep_cnt_r;
  logic [ADDR_BITS:0]   sweep_cnt_nxt_s;
  logic [15:0]          mem_r [DEPTH];

  logic [LAT-1:0]       pipe_vld_r;
  logic [LAT-1:0][15:0] pipe_data_r;

  logic                 byte_sel_s;
  logic                 acc_write_s;
  logic                 acc_read_s;
  logic                 in_range_s;
  logic [ADDR_BITS-1:0] mem_idx_s;
  logic [15:0]          raw_word_s;
  logic [15:0]          rd_word_s;
  logic                 sweep_we_s;
  logic                 host_we_s;
  logic                 rd_capture_s;
  logic                 err_inc_s;
  logic                 wr_inc_s;
  logic                 rd_inc_s;
  logic                 drive_s;

  // Pin classification of the current cycle
  always_comb begin
    byte_sel_s  = ~(bus.SRAM_UB & bus.SRAM_LB);
    acc_write_s = ~bus.SRAM_CE & ~bus.SRAM_WE & byte_sel_s;
    acc_read_s  = ~bus.SRAM_CE &  bus.SRAM_WE & ~bus.SRAM_OE & byte_sel_s;
    in_range_s  = ((bus.SRAM_ADDR >> ADDR_BITS) == 20'd0);
    mem_idx_s   = bus.SRAM_ADDR[ADDR_BITS-1:0];
  end

  // Read word: out-of-range reads return a marker, disabled lanes read zero
  always_comb begin
    raw_word_s = in_range_s ? mem_r[mem_idx_s] : 16'hDEAD;
    rd_word_s  = {(bus.SRAM_UB ? 8'h00 : raw_word_s[15:8]),
                  (bus.SRAM_LB ? 8'h00 : raw_word_s[7:0])};
  end

  // FSM next state and per-cycle action strobes
  always_comb begin
    state_nxt_s     = state_r;
    sweep_cnt_nxt_s = sweep_cnt_r;
    sweep_we_s      = 1'b0;
    host_we_s       = 1'b0;
    rd_capture_s    = 1'b0;
    err_inc_s       = 1'b0;
    wr_inc_s        = 1'b0;
    rd_inc_s        = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (sweep_cnt_r == SWEEP_END) begin
          state_nxt_s = ST_READY;
        end else begin
          sweep_we_s      = 1'b1;
          sweep_cnt_nxt_s = sweep_cnt_r + SWEEP_ONE;
        end
        // Host accesses during the sweep are dropped and flagged.
        err_inc_s = acc_write_s | acc_read_s;
      end
      ST_READY: begin
        if (acc_write_s) begin
          host_we_s = in_range_s;
          wr_inc_s  = in_range_s;
          // Out-of-range and OE/WE contention share one increment.
          err_inc_s = ~in_range_s | ~bus.SRAM_OE;
        end else if (acc_read_s) begin
          rd_capture_s = 1'b1;
          rd_inc_s     = in_range_s;
          err_inc_s    = ~in_range_s;
        end else begin
          err_inc_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s     = ST_INIT;
        sweep_cnt_nxt_s = SWEEP_ZERO;
      end
    endcase
  end

  // FSM state, sweep counter and status outputs
  always_ff @(posedge sram_clk) begin
    if (reset) begin
      state_r     <= ST_INIT;
      sweep_cnt_r <= SWEEP_ZERO;
      ready       <= 1'b0;
      err_count   <= 8'h00;
      wr_count    <= 16'h0000;
      rd_count    <= 16'h0000;
    end else begin
      state_r     <= state_nxt_s;
      sweep_cnt_r <= sweep_cnt_nxt_s;
      ready       <= (state_nxt_s == ST_READY);
      if (err_inc_s && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      if (wr_inc_s) begin
        wr_count <= wr_count + 16'd1;
      end
      if (rd_inc_s) begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end

  // Memory array: sweep fill during INIT, byte-masked host writes in READY.
  // Contents survive reset; only the restarted sweep overwrites them.
  always_ff @(posedge sram_clk) begin
    if (!reset && sweep_we_s) begin
      mem_r[sweep_cnt_r[ADDR_BITS-1:0]] <= INIT_VALUE;
    end else if (!reset && host_we_s) begin
      if (!bus.SRAM_LB) begin
        mem_r[mem_idx_s][7:0] <= SRAM_DQ[7:0];
      end
      if (!bus.SRAM_UB) begin
        mem_r[mem_idx_s][15:8] <= SRAM_DQ[15:8];
      end
    end
  end

  // Read pipeline: stage 0 captures, later stages shift toward the pins
  always_ff @(posedge sram_clk) begin
    if (reset) begin
      pipe_vld_r  <= {LAT{1'b0}};
      pipe_data_r <= {LAT{16'h0000}};
    end else begin
      pipe_vld_r[0]  <= rd_capture_s;
      pipe_data_r[0] <= rd_word_s;
      for (int i = 1; i < LAT; i++) begin
        pipe_vld_r[i]  <= pipe_vld_r[i-1];
        pipe_data_r[i] <= pipe_data_r[i-1];
      end
    end
  end

  // Output driver is gated by the live pins so a master turning the bus
  // around (WE low or OE high) never sees contention from the responder.
  always_comb begin
    drive_s = pipe_vld_r[LAT-1] & ~reset & ~bus.SRAM_CE & bus.SRAM_WE & ~bus.SRAM_OE;
  end

  assign SRAM_DQ = drive_s ? pipe_data_r[LAT-1] : 16'hzzzz;

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;
  localparam int          AB    = 4;
  localparam int          LAT   = 2;
  localparam logic [15:0] INIT  = 16'h0000;
  localparam int          DEPTH = 1 << AB;

  logic        clk = 1'b0;
  logic        reset;
  logic        tb_dq_en;
  logic [15:0] tb_dq;
  wire  [15:0] dq;
  logic        ready;
  logic [7:0]  err_count;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  sram_responder_if bus ();

  assign dq = tb_dq_en ? tb_dq : 16'hzzzz;

  sram_responder #(.ADDR_BITS(AB), .READ_LATENCY(LAT), .INIT_VALUE(INIT)) dut (
    .sram_clk (clk),
    .reset    (reset),
    .bus      (bus),
    .SRAM_DQ  (dq),
    .ready    (ready),
    .err_count(err_count),
    .wr_count (wr_count),
    .rd_count (rd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          is_dq;
    logic [15:0] dq;
    logic        rdy;
    logic [7:0]  err;
    logic [15:0] wr;
    logic [15:0] rd;
  } exp_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } pend_t;

  exp_t        q[$];
  pend_t       pend[$];
  logic [15:0] ref_mem [DEPTH];
  int          ref_err;
  logic [15:0] ref_wr;
  logic [15:0] ref_rd;
  int          edges;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every expectation that falls due in the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due < cyc) begin
          checks++;
          errors++;
          $display("FAIL stale_expectation: due %0d seen at %0d", e.due, cyc);
        end else if (e.is_dq) begin
          chk("sram_dq", dq, e.dq);
        end else begin
          chk("ready", {15'd0, ready}, {15'd0, e.rdy});
          chk("err_count", {8'd0, err_count}, {8'd0, e.err});
          chk("wr_count", wr_count, e.wr);
          chk("rd_count", rd_count, e.rd);
        end
      end
    end
  end

  // Reference model reset: the sweep leaves every word at INIT.
  task automatic model_reset();
    foreach (ref_mem[i]) ref_mem[i] = INIT;
    ref_err = 0;
    ref_wr  = 16'd0;
    ref_rd  = 16'd0;
    edges   = 0;
    pend.delete();
  endtask

  // Drive one cycle of pins, record expectations, advance to the next cycle.
  task automatic issue(input logic ce, input logic we, input logic oe, input logic ub,
                       input logic lb, input logic [19:0] addr, input logic [15:0] data,
                       input bit probe);
    exp_t        e;
    pend_t       p;
    logic        rcfg;
    logic        is_wr;
    logic        is_rd;
    logic        inr;
    logic        bump;
    logic [15:0] v;
    rcfg = !ce && we && !oe;
    bus.SRAM_CE = ce; bus.SRAM_WE = we; bus.SRAM_OE = oe;
    bus.SRAM_UB = ub; bus.SRAM_LB = lb; bus.SRAM_ADDR = addr;
    tb_dq_en = probe || !rcfg;
    tb_dq    = probe ? 16'h0000 : data;
    e = '{due: cyc, is_dq: 1'b1, dq: 16'h0000, rdy: 1'b0, err: 8'h00, wr: 16'h0000, rd: 16'h0000};
    if (tb_dq_en) begin
      e.dq = tb_dq;
      q.push_back(e);
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      e.dq = pend[0].data;
      q.push_back(e);
    end
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    edges++;
    is_wr = !ce && !we && !(ub && lb);
    is_rd = rcfg && !(ub && lb);
    inr   = (addr < DEPTH);
    bump  = 1'b0;
    if (edges <= DEPTH + 1) begin
      bump = is_wr || is_rd;
    end else begin
      if (is_wr) begin
        if (inr) begin
          if (!lb) ref_mem[addr[AB-1:0]][7:0]  = data[7:0];
          if (!ub) ref_mem[addr[AB-1:0]][15:8] = data[15:8];
          ref_wr++;
        end else begin
          bump = 1'b1;
        end
        if (!oe) bump = 1'b1;
      end
      if (is_rd) begin
        v = inr ? ref_mem[addr[AB-1:0]] : 16'hDEAD;
        if (ub) v[15:8] = 8'h00;
        if (lb) v[7:0]  = 8'h00;
        if (inr) ref_rd++;
        else bump = 1'b1;
        p.due  = cyc + LAT;
        p.data = v;
        pend.push_back(p);
      end
    end
    if (bump && ref_err < 255) ref_err++;
    e.due   = cyc + 1;
    e.is_dq = 1'b0;
    e.rdy   = (edges >= DEPTH + 1);
    e.err   = ref_err[7:0];
    e.wr    = ref_wr;
    e.rd    = ref_rd;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [19:0] a);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a, 16'h0000, 1'b0);
  endtask

  task automatic hold();
    issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'd0, 16'h0000, 1'b0);
  endtask

  task automatic idle();
    issue(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'd0, 16'h0000, 1'b0);
  endtask

  task automatic wr(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
    issue(1'b0, 1'b0, 1'b1, ub, lb, a, d, 1'b0);
  endtask

  // Hold reset for n edges with the pins in read position, then release and
  // probe the bus on the first cycle after release.
  task automatic do_reset(input int n);
    exp_t e;
    while (q.size() > 0 && q[q.size()-1].due >= cyc) void'(q.pop_back());
    model_reset();
    reset = 1'b1;
    bus.SRAM_CE = 1'b0; bus.SRAM_WE = 1'b1; bus.SRAM_OE = 1'b0;
    bus.SRAM_UB = 1'b1; bus.SRAM_LB = 1'b1; bus.SRAM_ADDR = 20'd0;
    tb_dq_en = 1'b1;
    tb_dq    = 16'h0000;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        e = '{due: cyc, is_dq: 1'b1, dq: 16'h0000, rdy: 1'b0, err: 8'h00, wr: 16'h0000, rd: 16'h0000};
        q.push_back(e);
      end
      e = '{due: cyc + 1, is_dq: 1'b0, dq: 16'h0000, rdy: 1'b0, err: 8'h00, wr: 16'h0000, rd: 16'h0000};
      q.push_back(e);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 20'd0, 16'h0000, 1'b1);
  endtask

  task automatic rand_op();
    int          k;
    logic [19:0] a;
    logic        ub;
    logic        lb;
    k  = $urandom_range(0, 99);
    a  = ($urandom_range(0, 9) == 0) ? 20'($urandom_range(DEPTH, 20'hFFFFF))
                                     : 20'($urandom_range(0, DEPTH - 1));
    ub = ($urandom_range(0, 3) == 0);
    lb = ($urandom_range(0, 3) == 0);
    if (k < 40) begin
      issue(1'b0, 1'b1, 1'b0, ub, lb, a, 16'h0000, 1'b0);
    end else if (k < 75) begin
      issue(1'b0, 1'b0, ($urandom_range(0, 9) != 0), ub, lb, a, 16'($urandom), 1'b0);
    end else if (k < 85) begin
      hold();
    end else begin
      issue(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), a,
            16'($urandom), 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    tb_dq_en = 1'b0;
    tb_dq = 16'h0000;
    bus.SRAM_CE = 1'b1; bus.SRAM_WE = 1'b1; bus.SRAM_OE = 1'b1;
    bus.SRAM_UB = 1'b1; bus.SRAM_LB = 1'b1; bus.SRAM_ADDR = 20'd0;
    model_reset();
    @(posedge clk);
    #1;

    // Init sweep timing, with a write and a read attempted mid-sweep.
    do_reset(1);
    for (int i = 0; i < DEPTH + 3; i++) begin
      if (i == 6)      wr(20'd2, 16'hFFFF, 1'b0, 1'b0);
      else if (i == 9) rd(20'd7);
      else             idle();
    end

    // Swept contents, byte-lane write, write-first read-back.
    rd(20'd5); hold(); hold();
    wr(20'd3, 16'hA5A5, 1'b1, 1'b0);
    rd(20'd3); hold(); hold();
    rd(20'd2); hold(); hold();

    // Back-to-back reads, then the bus released while a result is pending.
    wr(20'd1, 16'h1111, 1'b0, 1'b0);
    wr(20'd2, 16'h2222, 1'b0, 1'b0);
    rd(20'd1); rd(20'd2); hold(); hold();
    rd(20'd1); hold();
    issue(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 20'd1, 16'h0000, 1'b0);
    rd(20'd2); hold();
    wr(20'd4, 16'h8000, 1'b0, 1'b0);
    rd(20'd9); rd(20'd3);
    wr(20'd6, 16'h0000, 1'b0, 1'b0);
    hold(); hold();

    // Reset in the middle of a read pipeline; memory is re-swept.
    wr(20'd15, 16'hBEEF, 1'b0, 1'b0);
    rd(20'd15);
    do_reset(1);
    for (int i = 0; i < DEPTH + 2; i++) idle();
    rd(20'd15); hold(); hold();

    // Reset in the middle of the sweep.
    for (int i = 0; i < 5; i++) idle();
    do_reset(2);
    for (int i = 0; i < DEPTH + 2; i++) idle();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) rand_op();
    hold(); hold();

    // Error accounting and saturation.
    do_reset(1);
    for (int i = 0; i < DEPTH + 2; i++) idle();
    rd(20'h10000); hold(); hold();
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'd6, 16'h1234, 1'b0);
    rd(20'd6); hold(); hold();
    for (int i = 0; i < 300; i++) wr(20'h40000 | 20'(i), 16'(i), 1'b0, 1'b0);
    idle(); idle();

    for (int i = 0; i < 8 && q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter ADDR_BITS, default 12: implemented memory depth is 2^ADDR_BITS words of 16 bits.
REQ-002 Parameter READ_LATENCY, default 1, legal values 1 or 2: sram_clk cycles from a sampled read to valid SRAM_DQ data.
REQ-003 Parameter INIT_VALUE, default 16'h0000: value written to every word by the post-reset sweep.
REQ-004 sram_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 SRAM_CE  input  1  chip enable, active low.
REQ-007 SRAM_UB  input  1  upper byte [15:8] enable, active low.
REQ-008 SRAM_LB  input  1  lower byte [7:0] enable, active low.
REQ-009 SRAM_OE  input  1  output enable, active low.
REQ-010 SRAM_WE  input  1  write enable, active low.
REQ-011 SRAM_ADDR  input  20  word address.
REQ-012 SRAM_DQ  inout  16  bidirectional data; the responder drives it only as defined in REQ-020.
REQ-013 ready  output  1  high once the init sweep is complete.
REQ-014 err_count  output  8  saturating protocol-violation counter.
REQ-015 wr_count  output  16  accepted write counter, wraps.
REQ-016 rd_count  output  16  accepted read counter, wraps.

Function
REQ-017 Two-state FSM: INIT -> READY.
- INIT: an internal sweep counter writes INIT_VALUE to word 0 through word 2^ADDR_BITS-1, one word per cycle; ready=0.
- On the cycle after the last word is written, the FSM enters READY and ready=1.
- READY is terminal until reset.
REQ-018 Each rising edge in READY classifies the sampled pins.
- IDLE: CE=1, or UB=LB=1.
- WRITE: CE=0, WE=0, and at least one byte enable low.
- READ: CE=0, WE=1, OE=0, and at least one byte enable low.
- Any other combination is IDLE.
REQ-019 WRITE commits SRAM_DQ[7:0] if LB=0 and SRAM_DQ[15:8] if UB=0 at that edge; unselected bytes are unchanged; wr_count increments.
REQ-020 READ captures the memory word and byte enables into a READ_LATENCY-deep pipeline; rd_count increments.
- SRAM_DQ is driven while the final pipeline stage is valid AND current CE=0, WE=1, OE=0.
- Otherwise SRAM_DQ is high-Z.
- The drive gating is combinational on the current pins, so the responder never drives while WE=0.
REQ-021 Byte lanes disabled for a read return 8'h00 in that lane.
REQ-022 Write-first: a READ sampled on the edge after a WRITE to the same address returns the new data.
REQ-023 Back-to-back READs are fully pipelined: one result per cycle, each READ_LATENCY cycles after its sample.
REQ-024 Out of range (SRAM_ADDR[19:ADDR_BITS] != 0):
- WRITE: ignored.
- READ: returns 16'hDEAD after the normal latency.
- err_count increments; wr_count/rd_count do not.
REQ-025 CE=0, WE=0, OE=0 at the same edge: treated as WRITE; err_count also increments (contention flag).
REQ-026 Any non-IDLE access sampled in INIT: ignored, SRAM_DQ stays high-Z, err_count increments.
REQ-027 err_count saturates at 8'hFF. When several REQ-024/025/026 conditions coincide in one cycle, err_count increments by 1 only.

Reset
REQ-028 While reset=1 at a rising edge, outputs are cleared:
- ready=0, err_count=0, wr_count=0, rd_count=0.
- Read pipeline invalidated; SRAM_DQ high-Z.
- FSM to INIT; sweep counter to 0.
REQ-029 Reset asserted mid-sweep or in READY restarts the full sweep on the first edge after reset deasserts; memory contents are otherwise not cleared by reset itself.

Verification
REQ-030 Init: reset 1 cycle, ADDR_BITS=4 -> ready rises exactly 17 cycles after reset release; a subsequent read of address 5 returns 16'h0000.
REQ-031 Byte write: write 16'hA5A5 to address 3 with LB=0, UB=1 over INIT_VALUE 0 -> read of address 3 with both bytes enabled returns 16'h00A5.
REQ-032 Latency: READ_LATENCY=2, back-to-back reads of addresses 1, 2 -> data appears on edges +2 and +3; SRAM_DQ is high-Z when OE=1.
REQ-033 Errors:
- Read address 20'h10000 -> 16'hDEAD and err_count=1.
- Access with WE=OE=0 -> err_count=2.
- 300 further violations -> err_count=255.
REQ-034 Reset mid-op: assert reset during the sweep and again during a read pipeline -> SRAM_DQ high-Z the next cycle, all counters 0, and the sweep restarts from word 0.
